// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit operands summed DIGIT bits per clock, LSB first.
// Define DIGIT_SERIAL_ADDER_SUB_EN to add the sub input and the ovf output.
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   output logic             ovf,
`endif
   output logic             cout
);

   if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be a multiple of DIGIT >= 1");
   end

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic [DIGIT:0]   dsum;
   logic             last;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   logic             ovf_q, ovf_d;
   logic             msb_cin;
`endif

   // Operand registers shift right, so the active digit is always the low one.
   assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, carry_q};
   assign last = (cnt_q == CW'(N - 1));

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   // Carry into the MSB recovered from the MSB's own sum bit.
   assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = RUN;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
`else
               b_d     = b;
               carry_d = cin;
`endif
            end
         end
         RUN: begin
            sum_d[cnt_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
            carry_d = dsum[DIGIT];
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            if (last) begin
               cout_d  = dsum[DIGIT];
               cnt_d   = '0;
               state_d = DONE;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
               ovf_d   = msb_cin ^ dsum[DIGIT];
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: 16/4 instance plus an 8/1 bit-serial one.
// Sub/ovf vectors run only when DIGIT_SERIAL_ADDER_SUB_EN is defined.
module tb_digit_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
   logic [15:0] a, b, sum;
   logic        in8_valid, in8_ready, cin8, out8_valid, out8_ready, cout8;
   logic [7:0]  a8, b8, sum8;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
   logic        sub, ovf, sub8, ovf8;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      .sub(sub), .ovf(ovf),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
   );

   digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in8_valid), .in_ready(in8_ready),
      .a(a8), .b(b8), .cin(cin8),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      .sub(sub8), .ovf(ovf8),
`endif
      .out_valid(out8_valid), .out_ready(out8_ready),
      .sum(sum8), .cout(cout8)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic accept(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input logic ts);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_wait", 32'(in_ready), 32'd1);
      a = ta; b = tb_; cin = tc; in_valid = 1'b1;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      sub = ts;
`else
      if (ts) $display("note: sub requested but feature disabled");
`endif
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [15:0] ta,
                         input logic [15:0] tb_, input logic tc,
                         input logic [15:0] es, input logic ec);
      accept(ta, tb_, tc, 1'b0);
      wait_done(tag, 4);
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
      drain();
   endtask

   initial begin
      int n;
      rst = 1'b1;
      in_valid = 0; out_ready = 0; cin = 0; a = '0; b = '0;
      in8_valid = 0; out8_ready = 0; cin8 = 0; a8 = '0; b8 = '0;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      sub = 0; sub8 = 0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      run_op("carry8", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
      check("idle_ready", 32'(in_ready), 32'd1);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_hold_sum", 32'(sum), 32'h0100);
      run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      run_op("cin_wrap", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
      run_op("mix", 16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0);

      // Backpressure: result held, new operands refused while in DONE
      accept(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_done("bp", 4);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_sum", 32'(sum), 32'h5555);
         check("bp_cout", 32'(cout), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_ready", 32'(in_ready), 32'd1);
      check("bp_release_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_accept", 32'(in_ready), 32'd0);
      wait_done("bp_new", 4);
      check("bp_new_sum", 32'(sum), 32'h3333);
      check("bp_new_cout", 32'(cout), 32'd0);
      drain();

      // Reset mid-run with counter at 2
      accept(16'h1234, 16'h1111, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum", 32'(sum), 32'd0);
      check("mid_rst_cout", 32'(cout), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      run_op("after_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);

      // Bit-serial instance
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; in8_valid = 1'b1;
      @(posedge clk); #1;
      in8_valid = 1'b0;
      n = 0;
      while (!out8_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("bs_lat", 32'(n), 32'd8);
      check("bs_sum", 32'(sum8), 32'h00);
      check("bs_cout", 32'(cout8), 32'd1);
      out8_ready = 1'b1;
      @(posedge clk); #1;
      out8_ready = 1'b0;
      check("bs_idle", 32'(in8_ready), 32'd1);

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      accept(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_done("sub1", 4);
      check("sub1_sum", 32'(sum), 32'hFFFE);
      check("sub1_cout", 32'(cout), 32'd0);
      check("sub1_ovf", 32'(ovf), 32'd0);
      drain();
      accept(16'h8000, 16'h0001, 1'b1, 1'b1);
      wait_done("sub2", 4);
      check("sub2_sum", 32'(sum), 32'h7FFF);
      check("sub2_cout", 32'(cout), 32'd1);
      check("sub2_ovf", 32'(ovf), 32'd1);
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
